// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//
// Contents:
//   NOP_INST      - instruction substituted for a faulting fetch (addi x0, x0, 0)
//   FETCH_PC_W    - width of the pc field carried through the fetch queue
//   fetch_entry_t - one queued fetch result {pc, inst, fault}
//   fetch_state_t - fetch FSM states {FETCH, HALTED}
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // The queue carries a 32-bit pc, which matches the default XLEN.
    localparam int unsigned FETCH_PC_W = 32;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [31:0]           inst;
        logic                  fault;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch queue of fetch_entry_t with flush and a registered head.
//
// Ports:
//   clk_i        - clock, rising edge
//   reset_i      - synchronous active-high reset; clears pointers, count and head
//   flush_i      - drop every entry (a same-cycle pop is irrelevant, push is ignored)
//   push_i       - write push_data_i at the tail
//   push_data_i  - entry to enqueue
//   pop_i        - consume the head entry
//   head_valid_o - queue not empty
//   head_o       - head entry, registered so it stays stable while not popped
//   count_o      - number of stored entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    output logic                         head_valid_o,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    storage_q [DEPTH];
    fetch_entry_t    head_q, head_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] count_after_pop;
    logic            do_push, do_pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        do_pop          = pop_i && (count_q != '0);
        count_after_pop = count_q - CntW'(do_pop);
        do_push         = push_i && (count_after_pop != CntW'(DEPTH));
        rptr_d          = rptr_q;
        wptr_d          = wptr_q;
        count_d         = count_after_pop + CntW'(do_push);
        head_d          = head_q;

        if (do_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (do_push) begin
            wptr_d = ptr_inc(wptr_q);
        end

        // The head register mirrors storage[rptr]; refill it from whichever
        // source will hold the head after this edge.
        if (do_push && (count_after_pop == '0)) begin
            head_d = push_data_i;
        end else if (do_pop && (count_after_pop != '0)) begin
            head_d = storage_q[rptr_d];
        end

        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            head_d  = head_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            storage_q[wptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_o       = head_q;
    assign count_o      = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, synchronous instruction memory, a
// two-register fetch pipeline and a flushable fetch queue feeding decode.
//
// Pipeline: issue (memory read at edge) -> response register -> queue push.
// An issued fetch therefore reaches inst_valid three edges after its pc was loaded.
//
// Ports:
//   clk, reset                  - clock and synchronous active-high reset
//   redirect_valid/redirect_pc  - load a new pc, flush queue and in-flight fetches
//   inst_valid/inst_ready       - handshake to decode
//   inst_data/inst_pc/inst_fault- queue head {instruction, address, fault flag}
//   imem_we/imem_waddr/imem_wdata - memory load port (not affected by reset)
//
// Build option: define IFETCH_TRACE_EN to print every queue push.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [31:0]                   inst_data,
    output logic [XLEN-1:0]               inst_pc,
    output logic                          inst_fault,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata
);

    localparam int unsigned AddrW = $clog2(IMEM_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OccW  = CntW + 2;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_word;
    logic            pc_fault;
    logic            pop, issue, push;
    logic [OccW-1:0] occupancy;
    logic [CntW-1:0] fifo_count;

    logic            s1_valid_q;
    logic [XLEN-1:0] s1_pc_q;
    logic            s1_fault_q;
    logic [31:0]     rd_data_q;
    logic            s2_valid_q;
    fetch_entry_t    s2_entry_q;
    fetch_entry_t    head;

    logic [31:0]     imem_q [IMEM_DEPTH];

    assign pop      = inst_valid & inst_ready;
    assign pc_word  = pc_q >> 2;
    assign pc_fault = (pc_q[1:0] != 2'b00) || (pc_word >= XLEN'(IMEM_DEPTH));

    // Entries that will occupy the queue once everything in flight lands;
    // issuing only below FIFO_DEPTH means a push never finds the queue full.
    assign occupancy = OccW'(fifo_count) + OccW'(s1_valid_q) + OccW'(s2_valid_q)
                     - OccW'(pop);
    assign issue = (state_q == FETCH) && !redirect_valid
                 && (occupancy < OccW'(FIFO_DEPTH));
    assign push  = s2_valid_q && !redirect_valid;

    // Next-state: redirect wins over issue; a faulting issue halts with pc held.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = FETCH;
            pc_d    = redirect_pc;
        end else if (issue) begin
            if (pc_fault) begin
                state_d = HALTED;
            end else begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Read-before-write: a same-address read in the write cycle sees the old word.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
        rd_data_q <= imem_q[pc_q[AddrW+1:2]];
    end

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= issue;
            s2_valid_q <= s1_valid_q;
        end
    end

    // Payload registers are qualified by the valid bits above.
    always_ff @(posedge clk) begin
        s1_pc_q          <= pc_q;
        s1_fault_q       <= pc_fault;
        s2_entry_q.pc    <= FETCH_PC_W'(s1_pc_q);
        s2_entry_q.inst  <= s1_fault_q ? NOP_INST : rd_data_q;
        s2_entry_q.fault <= s1_fault_q;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .reset_i      (reset),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_data_i  (s2_entry_q),
        .pop_i        (pop),
        .head_valid_o (inst_valid),
        .head_o       (head),
        .count_o      (fifo_count)
    );

    assign inst_data  = head.inst;
    assign inst_pc    = XLEN'(head.pc);
    assign inst_fault = head.fault;

`ifdef IFETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            $display("ifetch push word=%0d inst=%b fault=%0b",
                     s2_entry_q.pc >> 2, s2_entry_q.inst, s2_entry_q.fault);
        end
    end
`else
    // Trace disabled: nothing extra is built.
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit (default parameters).
// Reference model: the expected delivery stream is the sequence of word
// addresses starting at the last redirect/reset target, each yielding the
// memory word or a NOP fault entry, ending after the first faulting address.
module tb_instruction_fetch_unit;

    localparam int unsigned IMEM_DEPTH = 256;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_model [IMEM_DEPTH];
    logic [31:0] exp_pc = '0;
    bit          exp_done = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .XLEN       (32),
        .IMEM_DEPTH (IMEM_DEPTH),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata)
    );

    function automatic bit model_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || ((pc >> 2) >= IMEM_DEPTH);
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] pc);
        if (model_fault(pc)) return NOP;
        return mem_model[pc[9:2]];
    endfunction

    // Consumer took the expected head: move the model to the next address.
    task automatic model_advance();
        if (model_fault(exp_pc)) exp_done = 1'b1;
        else exp_pc = exp_pc + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives inst_ready for n cycles, checking every valid head against the model.
    task automatic run_stream(input int n, input int ready_pct, input bit require_valid);
        for (int i = 0; i < n; i++) begin
            inst_ready = ($urandom_range(99) < ready_pct);
            if (inst_valid) begin
                checks++;
                if (exp_done || inst_pc !== exp_pc || inst_data !== model_inst(exp_pc)
                    || inst_fault !== model_fault(exp_pc)) begin
                    errors++;
                    $display("FAIL stream_head: got pc=%h data=%h fault=%b, want pc=%h data=%h fault=%b (stream_ended=%0d)",
                             inst_pc, inst_data, inst_fault, exp_pc, model_inst(exp_pc),
                             model_fault(exp_pc), exp_done);
                end
                if (inst_ready) model_advance();
            end else if (require_valid) begin
                checks++;
                errors++;
                $display("FAIL stream_gap: got inst_valid=0, want 1 (expected pc=%h)", exp_pc);
            end
            tick();
        end
    endtask

    // One redirect cycle (with ready high, so any head is popped), then the
    // target must appear exactly three edges later.
    task automatic redirect_to(input logic [31:0] tgt);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        if (inst_valid) begin
            checks++;
            if (exp_done || inst_pc !== exp_pc || inst_data !== model_inst(exp_pc)) begin
                errors++;
                $display("FAIL redirect_pop: got pc=%h data=%h, want pc=%h data=%h",
                         inst_pc, inst_data, exp_pc, model_inst(exp_pc));
            end
            model_advance();
        end
        exp_pc   = tgt;
        exp_done = 1'b0;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_bubble: edge N+%0d got inst_valid=%b, want 0", k, inst_valid);
            end
            tick();
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== tgt || inst_data !== model_inst(tgt)
            || inst_fault !== model_fault(tgt)) begin
            errors++;
            $display("FAIL redirect_target: got valid=%b pc=%h data=%h fault=%b, want 1 %h %h %b",
                     inst_valid, inst_pc, inst_data, inst_fault, tgt, model_inst(tgt),
                     model_fault(tgt));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            imem_we       = 1'b1;
            imem_waddr    = 8'(i);
            imem_wdata    = $urandom;
            mem_model[i]  = imem_wdata;
            tick();
        end
        imem_we = 1'b0;
        tick();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, want 0", inst_valid);
        end
        checks++;
        if (inst_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, want 00000000", inst_data);
        end
        checks++;
        if (inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h, want 00000000", inst_pc);
        end
        checks++;
        if (inst_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_fault: got %b, want 0", inst_fault);
        end
    endtask

    task automatic test_startup();
        reset      = 1'b0;
        inst_ready = 1'b1;
        exp_pc     = 32'h0;
        exp_done   = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL startup_latency: edge %0d got inst_valid=%b, want 0", k, inst_valid);
            end
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL startup_first: got valid=%b pc=%h, want 1 00000000", inst_valid, inst_pc);
        end
        run_stream(8, 100, 1'b1);
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== model_inst(exp_pc)) begin
                errors++;
                $display("FAIL stall_head: cycle %0d got valid=%b pc=%h data=%h, want 1 %h %h",
                         i, inst_valid, inst_pc, inst_data, exp_pc, model_inst(exp_pc));
            end
        end
        run_stream(12, 100, 1'b1);
    endtask

    task automatic test_redirect_flush();
        inst_ready = 1'b0;
        tick();
        tick();
        redirect_to(32'h20);
        run_stream(6, 100, 1'b1);
    endtask

    task automatic test_fault_halt();
        redirect_to(32'h22);
        run_stream(10, 100, 1'b0);
        checks++;
        if (!exp_done || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_halt: got fault_seen=%0d valid=%b, want 1 0", exp_done, inst_valid);
        end
        redirect_to(32'h0);
        run_stream(8, 100, 1'b1);
    endtask

    task automatic test_oob();
        redirect_to(32'h3F0);
        run_stream(12, 100, 1'b0);
        checks++;
        if (!exp_done || exp_pc !== 32'h400 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL oob_halt: got fault_seen=%0d last=%h valid=%b, want 1 00000400 0",
                     exp_done, exp_pc, inst_valid);
        end
    endtask

    task automatic test_reset_mid();
        redirect_to(32'h80);
        run_stream(3, 100, 1'b1);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        inst_ready     = 1'b1;
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        exp_pc         = 32'h0;
        exp_done       = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: got valid=%b data=%h pc=%h fault=%b, want 0 0 0 0",
                     inst_valid, inst_data, inst_pc, inst_fault);
        end
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_latency: edge %0d got inst_valid=%b, want 0", k, inst_valid);
            end
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== mem_model[0]) begin
            errors++;
            $display("FAIL midreset_refetch: got valid=%b pc=%h data=%h, want 1 00000000 %h",
                     inst_valid, inst_pc, inst_data, mem_model[0]);
        end
        run_stream(8, 100, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int r = 0; r < 8; r++) begin
            tgt = 32'($urandom_range(0, 250)) << 2;
            redirect_to(tgt);
            run_stream(40, int'($urandom_range(20, 100)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_flush();
        test_fault_halt();
        test_oob();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Clocked, parametrised instruction fetch stage for the sequential core. Holds the PC, reads a synchronous instruction memory, and buffers fetched words in a small flushable queue. Hands `{pc, instruction, fault}` to decode over a valid/ready handshake. Accepts branch/jump redirects from execute, with a loadable memory write port for test benches.

## Interface
- `XLEN`, 32: PC width.
- `IMEM_DEPTH`, 256: instruction memory words, power of two.
- `RESET_PC`, 0: PC after reset, word aligned.
- `FIFO_DEPTH`, 4: fetch queue entries, legal 2..16.

- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `redirect_valid`  in  1  load new PC this cycle.
- `redirect_pc`  in  XLEN  redirect target.
- `inst_valid`  out  1  queue head valid.
- `inst_ready`  in  1  decode accepts head.
- `inst_data`  out  32  instruction word.
- `inst_pc`  out  XLEN  address of `inst_data`.
- `inst_fault`  out  1  head is a fetch fault.
- `imem_we`  in  1  memory write enable.
- `imem_waddr`  in  $clog2(IMEM_DEPTH)  word index.
- `imem_wdata`  in  32  write data.

## Operation
- FSM states: FETCH and HALTED. Reset enters FETCH with `pc=RESET_PC`.
- Issue in FETCH when `count + inflight - pop < FIFO_DEPTH`, where `pop = inst_valid & inst_ready`.
  - The issue reads `imem[pc[$clog2(IMEM_DEPTH)+1:2]]`.
  - `pc` then advances by 4, wrapping modulo 2^XLEN.
- Pipeline: issue → response register (1 cycle) → queue push. `inflight` counts 0..2.
- Fault: `pc[1:0]!=0` or `pc>>2 >= IMEM_DEPTH` at issue.
  - The entry is marked with `inst_fault=1` and `inst_data=32'h00000013` (NOP).
  - The FSM enters HALTED and stops issuing; queued and inflight entries still drain.
- HALTED exits only on `redirect_valid` or `reset`.
- Redirect, with priority over everything except reset:
  - queue flushed, inflight discarded, `pc<=redirect_pc`, state forced to FETCH.
  - A pop in the same cycle still completes; the consumer owns that word.
- Memory write takes effect at the edge. A read in the same cycle at the same address returns the old word.
- Memory contents are not cleared by reset.
- Outputs are driven from the queue head. `inst_data`, `inst_pc` and `inst_fault` are held stable while `inst_valid & !inst_ready`.

## Timing
- Reset values: `inst_valid=0`, `inst_data=0`, `inst_pc=0`, `inst_fault=0`. Counts are 0 and state is FETCH.
- Latency: first issue in the cycle after reset deasserts; `inst_valid` rises 2 cycles later.
- A redirect sampled at edge N gives the target issue in cycle N+1 and `inst_valid` for the target after edge N+3.
- `inst_valid=0` from edge N+1 until the target arrives.
- Throughput is 1 instruction/cycle with `inst_ready` held high when `FIFO_DEPTH>=3`.
- Full queue with `inst_ready=0`: issue stops, no entry is dropped or overwritten, and `pc` holds.
- Reset mid-operation: queue, inflight work and state are cleared at that edge, including reset coincident with redirect.

## Configuration
- `IFETCH_TRACE_EN`
  - Defined: every queue push prints its PC word index, instruction in binary, and fault flag via `$display`.
  - Undefined: no display statements are compiled and behaviour is identical.

## Structure
- Package `fetch_pkg` holds:
  - the `NOP_INST` constant (32'h00000013);
  - the packed typedef `fetch_entry_t {pc, inst, fault}`;
  - the enum `fetch_state_t {FETCH, HALTED}`.
- One sub-module, `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with `flush`, `count` and a registered head.

## Test plan
- Load words 0..7, release reset, keep `inst_ready=1` → PCs 0,4,…,28 appear on consecutive cycles starting 2 cycles after reset release.
- Hold `inst_ready=0` for 10 cycles → exactly `FIFO_DEPTH` entries are queued and the head is stable. Release → order is preserved with no gaps or duplicates.
- Redirect to 0x20 while the queue holds 3 entries, with a pop in the same cycle → the popped word is accepted, the rest are flushed, and the next valid is `inst_pc=0x20` after 3 edges.
- Redirect to 0x22 → one entry with `inst_fault=1`, `inst_data=0x00000013`, then HALTED. A later redirect to 0x0 resumes fetch.
- Fetch up to PC 0x3FC with depth 256 → the next entry (0x400) faults and fetch halts.
- Assert reset mid-stream while `inst_valid=1` → `inst_valid=0` next cycle and refetch starts from `RESET_PC`. Memory contents are preserved.
